// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, oversampled majority-vote
// bit recovery, framing/parity/overrun/break detection and a small FWFT receive FIFO.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          din,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int MID     = OVERSAMPLE / 2;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Input synchroniser and edge detector; all flops idle high like the line.
  logic sync1_q, din_s_q, din_prev_q;

  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      din_s_q    <= 1'b1;
      din_prev_q <= 1'b1;
    end else begin
      sync1_q    <= din;
      din_s_q    <= sync1_q;
      din_prev_q <= din_s_q;
    end
  end

  logic start_edge;
  assign start_edge = din_prev_q & ~din_s_q;

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OS_W-1:0]      samp_q, samp_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  logic                 done_q, done_d;

  logic tick, sample_now, maj, exp_par;

  assign tick       = (state_q != S_IDLE) && (state_q != S_BREAK) && (div_q == DIV_W'(DIV - 1));
  assign sample_now = tick && (samp_q == OS_W'(MID + 1));
  assign maj        = (s0_q & s1_q) | (s0_q & din_s_q) | (s1_q & din_s_q);
  assign exp_par    = (PARITY == 1) ? ~^shift_q : ^shift_q;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    if (tick) begin
      samp_d = (samp_q == OS_W'(OVERSAMPLE - 1)) ? '0 : samp_q + OS_W'(1);
      if (samp_q == OS_W'(MID - 1)) s0_d = din_s_q;
      if (samp_q == OS_W'(MID))     s1_d = din_s_q;
    end

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        samp_d = '0;
        if (start_edge) begin
          state_d = S_START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          zero_d  = 1'b1;
        end
      end
      S_START: begin
        if (sample_now) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample_now) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~maj;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample_now) begin
          zero_d  = zero_q & ~maj;
          perr_d  = (maj != exp_par);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_now) begin
          zero_d = zero_q & ~maj;
          if (!maj) ferr_d = 1'b1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            // An all-zero frame is a line break; wait for the line to recover.
            state_d = (zero_q & ~maj) ? S_BREAK : S_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        div_d  = '0;
        samp_d = '0;
        if (din_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  // Frame completion and FIFO control.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 good, pop, push, full;

  assign good = done_q & ~ferr_q & ~perr_q;
  assign pop  = rd_en & (count_q != '0);
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign push = good & (~full | pop);

  assign frame_err  = done_q & ferr_q;
  assign parity_err = done_q & ~ferr_q & perr_q;
  assign overrun    = good & full & ~pop;

  // NOTE: the storage array has no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 and an 8E1 instance at a fast
// bit rate, a scoreboard queue of expected words, and pulse counters for errors.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int DIV      = 2;
  localparam int BIT      = DIV * OS;
  // Posedges from driving an 8N1 start bit to the cycle in which its push is decided:
  // 3 cycles of synchroniser/edge latency, then tick OS/2+1 of the stop bit (bit 9), plus one.
  localparam int PUSH_OFS = 3 + DIV * (OS * 9 + OS / 2 + 2);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din_a = 1'b1, din_b = 1'b1;
  logic       rd_a = 1'b0, rd_b = 1'b0;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic [2:0] count_a, count_b;
  logic       frame_err_a, parity_err_a, overrun_a;
  logic       frame_err_b, parity_err_b, overrun_b;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .rd_en(rd_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .fifo_count(count_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a)
  );

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .rd_en(rd_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .fifo_count(count_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_a = 0, perr_a = 0, ovr_a = 0;
  int ferr_b = 0, perr_b = 0, ovr_b = 0;
  logic [7:0] exp_q[$];
  bit use_b = 1'b0;

  always @(negedge clk) begin
    if (frame_err_a)  ferr_a++;
    if (parity_err_a) perr_a++;
    if (overrun_a)    ovr_a++;
    if (frame_err_b)  ferr_b++;
    if (parity_err_b) perr_b++;
    if (overrun_b)    ovr_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_valid();
    return use_b ? rx_valid_b : rx_valid_a;
  endfunction

  function automatic logic [7:0] cur_data();
    return use_b ? rx_data_b : rx_data_a;
  endfunction

  function automatic logic [2:0] cur_count();
    return use_b ? count_b : count_a;
  endfunction

  task automatic set_din(input logic v);
    if (use_b) din_b = v;
    else       din_a = v;
  endtask

  task automatic set_rd(input logic v);
    if (use_b) rd_b = v;
    else       rd_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    set_din(v);
    idle(BIT);
  endtask

  task automatic send(input logic [7:0] d, input logic par_en, input logic par_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_val);
    drive_bit(1'b1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    int t;
    t = 0;
    @(negedge clk);
    while (!cur_valid() && t < 4 * BIT) begin
      @(negedge clk);
      t++;
    end
    if (!cur_valid()) begin
      check({tag, "_valid"}, 32'(cur_valid()), 32'd1);
      idle(1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
      idle(1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(cur_data()), 32'(e));
      idle(1);
      set_rd(1'b1);
      idle(1);
      set_rd(1'b0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, p0, o0;

    // Reset state
    idle(5);
    @(negedge clk);
    check("rst_valid", 32'(rx_valid_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_data", 32'(rx_data_a), 32'd0);
    check("rst_errs", 32'({frame_err_a, parity_err_a, overrun_a}), 32'd0);
    idle(1);
    reset = 1'b1;
    idle(10);

    // 8N1, 0x41
    use_b = 1'b0;
    f0 = ferr_a; p0 = perr_a; o0 = ovr_a;
    exp_q.push_back(8'h41);
    send(8'h41, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(rx_valid_a), 32'd1);
    check("t1_count", 32'(count_a), 32'd1);
    pop_check("t1_data");
    check("t1_errs", 32'((ferr_a - f0) + (perr_a - p0) + (ovr_a - o0)), 32'd0);

    // 0.3-bit glitch is rejected as a false start
    f0 = ferr_a; p0 = perr_a; o0 = ovr_a;
    set_din(1'b0);
    idle(BIT * 3 / 10);
    set_din(1'b1);
    idle(2 * BIT);
    check("t2_count", 32'(count_a), 32'd0);
    check("t2_errs", 32'((ferr_a - f0) + (perr_a - p0) + (ovr_a - o0)), 32'd0);
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b0, 1'b0);
    pop_check("t2_data");

    // Even parity instance: bad then good parity on 0x07
    use_b = 1'b1;
    f0 = ferr_b; p0 = perr_b;
    send(8'h07, 1'b1, 1'b0);
    idle(BIT);
    check("t3_perr", 32'(perr_b - p0), 32'd1);
    check("t3_count", 32'(count_b), 32'd0);
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, ^8'h07);
    pop_check("t3_data");
    check("t3_ferr", 32'(ferr_b - f0), 32'd0);
    check("t3_perr_once", 32'(perr_b - p0), 32'd1);
    use_b = 1'b0;

    // Overrun: five back-to-back frames into a 4-deep FIFO
    o0 = ovr_a;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b0, 1'b0);
    end
    send(8'h05, 1'b0, 1'b0);
    idle(BIT);
    check("t4_ovr", 32'(ovr_a - o0), 32'd1);
    check("t4_full", 32'(count_a), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("t4_pop");
    check("t4_empty", 32'(count_a), 32'd0);

    // Same again, but pop in the push cycle of the fifth frame
    o0 = ovr_a;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b0, 1'b0);
    end
    fork
      send(8'h05, 1'b0, 1'b0);
      begin
        repeat (PUSH_OFS) @(posedge clk);
        #1;
        rd_a = 1'b1;
        @(negedge clk);
        check("t4b_head", 32'(rx_data_a), 32'(exp_q.pop_front()));
        check("t4b_no_ovr_now", 32'(overrun_a), 32'd0);
        @(posedge clk);
        #1;
        rd_a = 1'b0;
      end
    join
    exp_q.push_back(8'h05);
    idle(BIT);
    check("t4b_ovr", 32'(ovr_a - o0), 32'd0);
    check("t4b_count", 32'(count_a), 32'd4);
    for (int i = 0; i < 4; i++) pop_check("t4b_pop");

    // Break: line low for three frame times
    f0 = ferr_a;
    set_din(1'b0);
    idle(30 * BIT);
    set_din(1'b1);
    idle(2 * BIT);
    check("t5_ferr", 32'(ferr_a - f0), 32'd1);
    check("t5_count", 32'(count_a), 32'd0);
    exp_q.push_back(8'h55);
    send(8'h55, 1'b0, 1'b0);
    pop_check("t5_data");

    // Reset in the middle of data bit 4
    send(8'h12, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_pre_count", 32'(count_a), 32'd1);
    idle(1);
    fork
      send(8'hAA, 1'b0, 1'b0);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_count", 32'(count_a), 32'd0);
        check("t6_valid", 32'(rx_valid_a), 32'd0);
        check("t6_data", 32'(rx_data_a), 32'd0);
      end
    join
    exp_q.delete();
    f0 = ferr_a; p0 = perr_a; o0 = ovr_a;
    idle(BIT);
    reset = 1'b1;
    idle(BIT);
    check("t6_after_count", 32'(count_a), 32'd0);
    exp_q.push_back(8'hAA);
    send(8'hAA, 1'b0, 1'b0);
    pop_check("t6_next");
    check("t6_errs", 32'((ferr_a - f0) + (perr_a - p0) + (ovr_a - o0)), 32'd0);
    check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
